// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit turning byte/half/word requests into word-aligned memory accesses
//
// Accepts one load or store at a time (RISC-V funct3 size/sign encoding) and
// issues one or two word-aligned accesses on the data-memory port, splitting
// accesses that straddle a word boundary. Load data is realigned and sign- or
// zero-extended before it is returned. Every output comes straight from a flop.
//
// Ports:
//   I_clk, I_rst          clock, synchronous active-high reset
//   I_req/I_we/I_funct3   request valid, store select, size/sign code
//   I_addr, I_wdata       byte address, right-justified store data
//   O_busy, O_done, O_err request in flight, completion pulse, illegal funct3
//   O_rdata               extended load result, held until the next O_done
//   O_maddr/O_mdata       word address and lane-aligned store data to memory
//   O_mmask, O_mwe        byte-lane enables and write enable to memory
//   I_mdata, I_mstall     registered read data and stall from memory
module lsu (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_req,
  input  logic        I_we,
  input  logic [2:0]  I_funct3,
  input  logic [31:0] I_addr,
  input  logic [31:0] I_wdata,
  output logic        O_busy,
  output logic        O_done,
  output logic        O_err,
  output logic [31:0] O_rdata,
  output logic [31:0] O_maddr,
  output logic [31:0] O_mdata,
  output logic [3:0]  O_mmask,
  output logic        O_mwe,
  input  logic [31:0] I_mdata,
  input  logic        I_mstall
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC1,
    ST_CAP1,
    ST_ACC2,
    ST_CAP2,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  // latched request
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ill_q, ill_d;

  // captured read words; only the low three bytes of the second word can
  // ever reach the result
  logic [31:0] lo_q, lo_d;
  logic [23:0] hi_q, hi_d;

  // output registers
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] mdata_q, mdata_d;
  logic [3:0]  mmask_q, mmask_d;
  logic        mwe_q, mwe_d;

  // request-derived helpers
  logic [1:0]  off;
  logic [7:0]  span_base;
  logic [7:0]  span;
  logic        split;
  logic [31:0] word_base;
  logic [31:0] rot_wdata;
  logic [31:0] shifted;
  logic [31:0] ext;

  function automatic logic is_illegal(input logic [2:0] f3, input logic we);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
  endfunction

  always_comb begin
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ill_d    = ill_q;
    if (state_q == ST_IDLE && I_req) begin
      we_d     = I_we;
      funct3_d = I_funct3;
      addr_d   = I_addr;
      wdata_d  = I_wdata;
      ill_d    = is_illegal(I_funct3, I_we);
    end
  end

  // span holds the byte enables of both words: [3:0] first word, [7:4] second
  always_comb begin
    off = addr_d[1:0];
    case (funct3_d[1:0])
      2'b00:   span_base = 8'h01;
      2'b01:   span_base = 8'h03;
      default: span_base = 8'h0F;
    endcase
    span      = span_base << off;
    split     = |span[7:4];
    word_base = {addr_d[31:2], 2'b00};
    case (off)
      2'd0:    rot_wdata = wdata_d;
      2'd1:    rot_wdata = {wdata_d[23:0], wdata_d[31:24]};
      2'd2:    rot_wdata = {wdata_d[15:0], wdata_d[31:16]};
      default: rot_wdata = {wdata_d[7:0],  wdata_d[31:8]};
    endcase
  end

  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    if (state_q == ST_CAP1) lo_d = I_mdata;
    if (state_q == ST_CAP2) hi_d = I_mdata[23:0];
  end

  // result uses the capture values of this cycle so DONE can present it
  always_comb begin
    case (off)
      2'd0:    shifted = lo_d;
      2'd1:    shifted = {hi_d[7:0],  lo_d[31:8]};
      2'd2:    shifted = {hi_d[15:0], lo_d[31:16]};
      default: shifted = {hi_d[23:0], lo_d[31:24]};
    endcase
    case (funct3_d)
      3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ext = {24'h0, shifted[7:0]};
      3'b101:  ext = {16'h0, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (I_req) state_d = is_illegal(I_funct3, I_we) ? ST_DONE : ST_ACC1;
      end
      ST_ACC1: begin
        if (!I_mstall) begin
          if (!we_q)      state_d = ST_CAP1;
          else if (split) state_d = ST_ACC2;
          else            state_d = ST_DONE;
        end
      end
      ST_CAP1: state_d = split ? ST_ACC2 : ST_DONE;
      ST_ACC2: begin
        if (!I_mstall) state_d = we_q ? ST_DONE : ST_CAP2;
      end
      ST_CAP2: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered values line up
  // with the state they belong to; address, mask and data hold outside ACC.
  always_comb begin
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    err_d   = (state_d == ST_DONE) && ill_d;
    rdata_d = rdata_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    mmask_d = mmask_q;
    mwe_d   = 1'b0;
    case (state_d)
      ST_ACC1: begin
        maddr_d = word_base;
        mmask_d = span[3:0];
        mdata_d = rot_wdata;
        mwe_d   = we_d;
      end
      ST_ACC2: begin
        maddr_d = word_base + 32'd4;
        mmask_d = span[7:4];
        mdata_d = rot_wdata;
        mwe_d   = we_d;
      end
      ST_DONE: begin
        if (!we_d && !ill_d) rdata_d = ext;
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      ill_q    <= 1'b0;
      lo_q     <= 32'h0;
      hi_q     <= 24'h0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      maddr_q  <= 32'h0;
      mdata_q  <= 32'h0;
      mmask_q  <= 4'h0;
      mwe_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ill_q    <= ill_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      maddr_q  <= maddr_d;
      mdata_q  <= mdata_d;
      mmask_q  <= mmask_d;
      mwe_q    <= mwe_d;
    end
  end

  assign O_busy  = busy_q;
  assign O_done  = done_q;
  assign O_err   = err_q;
  assign O_rdata = rdata_q;
  assign O_maddr = maddr_q;
  assign O_mdata = mdata_q;
  assign O_mmask = mmask_q;
  assign O_mwe   = mwe_q;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit that initiates data-memory transactions on behalf of the core. It takes one load or store request at a time, with RISC-V funct3 size and sign encoding, and turns it into word-aligned accesses on the data-memory port. A misaligned access that crosses a word boundary is split into two accesses. Load results are aligned and sign- or zero-extended before return. It drives the memory's address, data, byte-mask and write-enable inputs, and consumes its registered read data and stall.

## Interface
Parameters: none.

- I_clk  in  1  clock; all state changes on the rising edge
- I_rst  in  1  reset, synchronous, active-high
- I_req  in  1  request valid; sampled only while O_busy=0
- I_we  in  1  1=store, 0=load
- I_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (loads only)
- I_addr  in  32  byte address
- I_wdata  in  32  store data, right-justified
- O_busy  out  1  request in flight
- O_done  out  1  one-cycle completion pulse
- O_err  out  1  valid with O_done; illegal funct3
- O_rdata  out  32  load result; valid while O_done=1, held until next O_done
- O_maddr  out  32  word address to memory, bits [1:0]=0
- O_mdata  out  32  lane-aligned store data
- O_mmask  out  4  byte enables, bit n = byte lane n
- O_mwe  out  1  memory write enable
- I_mdata  in  32  memory read data, registered one cycle after the address
- I_mstall  in  1  memory stall; the current access is not taken while this is high

## Operation
- States: IDLE, ACC1, CAP1, ACC2, CAP2, DONE.
- IDLE:
  - If I_req=1, latch the request, set O_busy=1 and go to ACC1.
  - If funct3 is illegal (011, 110, 111, or a store with funct3[2]=1), go straight to DONE with O_err=1 and make no memory access.
- Definitions:
  - off = addr[1:0]; size = 1, 2 or 4 bytes.
  - split = off+size > 4.
- ACC1:
  - O_maddr = {addr[31:2],2'b00}.
  - O_mmask = the bytes from off up to min(off+size,4)-1.
  - O_mwe = I_we.
  - O_mdata = wdata rotated left by 8*off.
  - If I_mstall=1, stay and hold all outputs.
  - Otherwise: a load goes to CAP1; a store goes to ACC2 if split, else DONE.
- CAP1: capture I_mdata into lo; O_mwe=0; go to ACC2 if split, else DONE.
- ACC2:
  - O_maddr = O_maddr+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - O_mmask = the remaining low-order bytes: ((1<<(off+size-4))-1).
  - Same rotated O_mdata; stall rule as ACC1.
  - A load goes to CAP2; a store goes to DONE.
- CAP2: capture I_mdata into hi; go to DONE.
- DONE:
  - O_done=1.
  - For loads, O_rdata = ({hi,lo} >> 8*off)[31:0], then extended per funct3: B/H sign-extend, BU/HU zero-extend, W unchanged.
  - Go to IDLE; O_busy=0 in the IDLE cycle.
- O_mwe=1 only in ACC1/ACC2 for stores. O_mmask and O_maddr are don't-care outside ACC states, but must be stable.
- I_req while busy is ignored and is not queued.
- Reset at any point:
  - All outputs are 0 on the cycle after the reset edge, and state is IDLE.
  - A store split across two accesses may be left half-written; this is accepted.

## Timing
- Accept edge = the edge at which IDLE sees I_req=1. Latencies below are in cycles from the accept edge to O_done, with no stalls.
  - Aligned store: 2.
  - Aligned load: 3.
  - Split store: 3.
  - Split load: 5.
  - Illegal funct3: 1.
- Each stall cycle in ACC1 or ACC2 adds exactly 1 cycle.
- All outputs are registered; there is no combinational path from I_mdata or I_mstall to any output.
- A new request can be accepted in the first IDLE cycle after DONE (back-to-back throughput: latency+1).

## Test plan
- SB, I_addr=0x103, I_wdata=0x000000A5:
  - One access: O_maddr=0x100, O_mmask=1000, O_mdata=0xA5000000, O_mwe=1.
  - O_done 2 cycles after accept.
- mem[0x100]=0x80FF1234:
  - LB at 0x103 -> O_rdata=0xFFFFFF80.
  - LBU at 0x103 -> 0x00000080.
  - LHU at 0x102 -> 0x000080FF.
  - Each with O_done 3 cycles after accept.
- SW, I_addr=0x102, I_wdata=0x11223344:
  - Access 1: 0x100 mask 1100, data 0x33441122. Access 2: 0x104 mask 0011, same data.
  - A following LW at 0x102 returns 0x11223344 in 5 cycles.
- LH at 0xFFFFFFFF with mem[0xFFFFFFFC]=0xAB000000 and mem[0x0]=0x000000CD:
  - Second O_maddr=0x00000000.
  - O_rdata=0xFFFFCDAB.
- I_mstall=1 for 2 cycles in ACC1 of an aligned LW:
  - O_maddr, O_mmask and O_mwe are held.
  - O_done arrives at 5 cycles.
  - I_req pulsed during busy is ignored.
- Reset and illegal funct3:
  - I_rst during CAP1 of a split load -> next cycle O_busy=0, O_done=0, O_mwe=0; a subsequent LW completes normally.
  - funct3=011 -> O_done=O_err=1 one cycle after accept, with no O_mwe pulse.
